// File: rtl/freq_sel_pkg.sv
// Shared definitions for the operator frequency-select path.
// Holds the sel_freq code points (also decoded by the downstream divider),
// the button debounce FSM state encoding and a one-hot LED decode helper.
package freq_sel_pkg;

  // Frequency select codes seen by the 100 MHz divider.
  localparam logic [1:0] SEL_1HZ  = 2'd0;
  localparam logic [1:0] SEL_2HZ  = 2'd1;
  localparam logic [1:0] SEL_5HZ  = 2'd2;
  localparam logic [1:0] SEL_10HZ = 2'd3;

  // Per-button debounce FSM states. The debounced level is high in
  // PRESSED and CHECK_RELEASE.
  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    CHECK_PRESS   = 2'd1,
    PRESSED       = 2'd2,
    CHECK_RELEASE = 2'd3
  } db_state_e;

  // One-hot LED pattern for a select code: bit n set when sel == n.
  function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage : freq_sel_pkg

// File: rtl/btn_debounce.sv
// Purpose : 2-flop synchronizer plus debounce FSM for one raw push button.
// Latency : press_evt fires DEBOUNCE_CYCLES cycles after the first synchronized-high cycle.
// Backpressure: none; the raw button is sampled every cycle, press_evt is a single-cycle pulse.
//
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-high reset
//   btn       - raw button, asynchronous to clk, active-high
//   level     - debounced button level (high in PRESSED / CHECK_RELEASE)
//   press_evt - one-cycle pulse on the CHECK_PRESS -> PRESSED transition
module btn_debounce
  import freq_sel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press_evt
);

  // The counter only ever has to reach DEBOUNCE_CYCLES-1; keep at least one
  // bit so a degenerate DEBOUNCE_CYCLES of 1 still elaborates.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  db_state_e     state_q;
  db_state_e     state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Two-flop synchronizer; nothing downstream looks at the raw input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Each CHECK_* state needs DEBOUNCE_CYCLES consecutive cycles of the new
  // value (counter 0..DEBOUNCE_CYCLES-1); any opposite sample aborts back to
  // the state it came from with the counter cleared.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_evt = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sync2_q) begin
          state_d = CHECK_PRESS;
        end
      end
      CHECK_PRESS: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = PRESSED;
          cnt_d     = '0;
          press_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        cnt_d = '0;
        if (!sync2_q) begin
          state_d = CHECK_RELEASE;
        end
      end
      CHECK_RELEASE: begin
        if (sync2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level = (state_q == PRESSED) || (state_q == CHECK_RELEASE);

endmodule : btn_debounce

// File: rtl/freq_sel_ctrl.sv
// Purpose : operator up/down buttons -> 2-bit sel_freq for the 100 MHz divider, LED and change strobe.
// Latency : sel_freq/led_sel/sel_changed register one cycle after a debounced press event.
// Backpressure: none; inputs are free-running buttons and outputs update every cycle.
//
// Ports:
//   clk         - system clock (100 MHz)
//   rst         - asynchronous active-high reset
//   btn_up      - raw up button, asynchronous to clk
//   btn_dn      - raw down button, asynchronous to clk
//   sel_freq    - divider select: 0=1 Hz, 1=2 Hz, 2=5 Hz, 3=10 Hz
//   sel_changed - one-cycle pulse in the cycle sel_freq takes a new value
//   led_sel     - one-hot copy of sel_freq
module freq_sel_ctrl
  import freq_sel_pkg::*;
#(
  parameter int unsigned SYS_FREQ        = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned HOLD_CYCLES     = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_dn,
  output logic [1:0] sel_freq,
  output logic       sel_changed,
  output logic [3:0] led_sel
);

  // SYS_FREQ only documents the clock the cycle counts are derived from; it
  // appears solely in this elaboration-time sanity guard.
  if (SYS_FREQ == 0) begin : g_sys_freq_zero
  end

  // The hold counter must be able to hold HOLD_CYCLES itself (its saturation
  // value), hence the +1 before taking the log.
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic          up_level_unused;
  logic          up_evt;
  logic          dn_level;
  logic          dn_evt;

  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic          hold_clr;

  logic [1:0]    sel_q;
  logic [1:0]    sel_d;
  logic          chg_q;
  logic          chg_d;
  logic [3:0]    led_q;
  logic [3:0]    led_d;

  // The up button only acts on press events; its level is not needed here.
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_up (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn_up),
    .level    (up_level_unused),
    .press_evt(up_evt)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_dn (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn_dn),
    .level    (dn_level),
    .press_evt(dn_evt)
  );

  // Hold counter: number of consecutive cycles the debounced down level has
  // been high, saturating. The clear fires on the cycle that takes it to
  // HOLD_CYCLES; saturation makes that happen once per press.
  always_comb begin
    hold_d   = hold_q;
    hold_clr = 1'b0;
    if (!dn_level) begin
      hold_d = '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d   = hold_q + 1'b1;
      hold_clr = (hold_q == HOLD_LAST);
    end
  end

  // Selection update. The long-hold clear overrides any same-cycle event;
  // simultaneous up and down presses cancel.
  always_comb begin
    sel_d = sel_q;
    if (hold_clr) begin
      sel_d = SEL_1HZ;
    end else if (up_evt && !dn_evt) begin
      sel_d = sel_q + 2'd1;
    end else if (dn_evt && !up_evt) begin
      sel_d = sel_q - 2'd1;
    end
    chg_d = (sel_d != sel_q);
    led_d = sel_onehot(sel_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      sel_q  <= SEL_1HZ;
      chg_q  <= 1'b0;
      led_q  <= 4'b0001;
    end else begin
      hold_q <= hold_d;
      sel_q  <= sel_d;
      chg_q  <= chg_d;
      led_q  <= led_d;
    end
  end

  assign sel_freq    = sel_q;
  assign sel_changed = chg_q;
  assign led_sel     = led_q;

endmodule : freq_sel_ctrl
